// File: rtl/mem_pkg.sv
// Shared encodings, state type and address window for the data-memory access controller.
package mem_pkg;

  // Request size encodings
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Default valid data window (inclusive at both ends)
  localparam logic [31:0] MEM_BASE_DEF = 32'h7FF0_0000;
  localparam logic [31:0] MEM_TOP_DEF  = 32'h7FFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

  // A request faults when its byte address leaves the window, it is misaligned
  // for its size, or it uses the reserved size code.
  function automatic logic access_fault(input logic [31:0] addr,
                                        input logic [1:0]  size,
                                        input logic [31:0] base,
                                        input logic [31:0] top);
    logic f;
    f = (addr < base) || (addr > top);
    case (size)
      SZ_HALF: f = f || addr[0];
      SZ_WORD: f = f || (addr[1:0] != 2'b00);
      SZ_RSVD: f = 1'b1;
      default: f = f;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Little-endian lane logic: pulls a byte/half out of a word with sign or zero
// extension, and builds the read-modify-write word for sub-word stores.
module byte_lane_merge
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] lane_data_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic        sign_i,
  output logic [31:0] load_val_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane selection, extension and store merge, all purely combinational
  always_comb begin
    case (offset_i)
      2'd0:    byte_v = word_i[7:0];
      2'd1:    byte_v = word_i[15:8];
      2'd2:    byte_v = word_i[23:16];
      default: byte_v = word_i[31:24];
    endcase
    half_v     = offset_i[1] ? word_i[31:16] : word_i[15:0];
    load_val_o = word_i;
    merged_o   = word_i;
    case (size_i)
      SZ_BYTE: begin
        load_val_o = {{24{sign_i & byte_v[7]}}, byte_v};
        case (offset_i)
          2'd0:    merged_o[7:0]   = lane_data_i[7:0];
          2'd1:    merged_o[15:8]  = lane_data_i[7:0];
          2'd2:    merged_o[23:16] = lane_data_i[7:0];
          default: merged_o[31:24] = lane_data_i[7:0];
        endcase
      end
      SZ_HALF: begin
        load_val_o = {{16{sign_i & half_v[15]}}, half_v};
        if (offset_i[1]) merged_o[31:16] = lane_data_i[15:0];
        else             merged_o[15:0]  = lane_data_i[15:0];
      end
      default: begin
        load_val_o = word_i;
        merged_o   = lane_data_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator towards DATA_MEMORY: one load/store at a time, range/alignment
// checking, load extension and byte/half stores by read-modify-write.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter logic [31:0] MEM_BASE = MEM_BASE_DEF,
  parameter logic [31:0] MEM_TOP  = MEM_TOP_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [1:0]  offset_q, offset_d;
  logic [31:0] wdata_q, wdata_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_fault_q, resp_fault_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic [31:0] load_val;
  logic [31:0] merged;

  // Lane logic always works on the live memory word and the captured request
  byte_lane_merge u_lane (
    .word_i      (mem_rdata),
    .lane_data_i (wdata_q),
    .size_i      (size_q),
    .offset_i    (offset_q),
    .sign_i      (sign_q),
    .load_val_o  (load_val),
    .merged_o    (merged)
  );

  // Next-state and next-output logic; every output is registered
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    size_d       = size_q;
    sign_d       = sign_q;
    offset_d     = offset_q;
    wdata_d      = wdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_write_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_fault_d = 1'b0;
    resp_rdata_d = 32'h0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          write_d    = req_write;
          size_d     = req_size;
          sign_d     = req_sign;
          offset_d   = req_addr[1:0];
          wdata_d    = req_wdata;
          mem_addr_d = {req_addr[31:2], 2'b00};
          if (access_fault(req_addr, req_size, MEM_BASE, MEM_TOP)) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
          end else if (req_write && (req_size == SZ_WORD)) begin
            // Full-word store needs no read of the old contents
            state_d     = WRITE;
            mem_write_d = 1'b1;
            mem_wdata_d = req_wdata;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (write_q) begin
          state_d     = WRITE;
          mem_write_d = 1'b1;
          mem_wdata_d = merged;
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_val;
        end
      end
      WRITE: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    req_ready_d = (state_d == IDLE);
  end

  // State and output registers; reset aborts any in-flight access at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      size_q       <= SZ_BYTE;
      sign_q       <= 1'b0;
      offset_q     <= 2'b00;
      wdata_q      <= 32'h0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      size_q       <= size_d;
      sign_q       <= sign_d;
      offset_q     <= offset_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_fault_q <= resp_fault_d;
      resp_rdata_q <= resp_rdata_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_fault = resp_fault_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl with a small DATA_MEMORY window at the top of the range.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_sign = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_sign   (req_sign),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // DATA_MEMORY: 16 words at 7FFFFFC0..7FFFFFFF, reads 0 elsewhere
  logic [31:0] dmem [0:15];
  logic        mem_clear = 1'b1;
  logic        in_win;
  assign in_win    = (mem_addr[31:6] == 26'h1FF_FFFF);
  assign mem_rdata = in_win ? dmem[mem_addr[5:2]] : 32'h0;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 16; i++) dmem[i] <= 32'h0;
    end else if (mem_write && in_win) begin
      dmem[mem_addr[5:2]] <= mem_wdata;
    end
  end

  int mw_count = 0;
  int oow_writes = 0;
  always @(posedge clk) begin
    if (mem_write) mw_count <= mw_count + 1;
    if (mem_write && !in_win) oow_writes <= oow_writes + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          due;
    bit          fault;
    logic [31:0] rdata;
    bit          wr;
    logic [31:0] waddr;
    logic [31:0] wword;
  } exp_t;

  exp_t        q[$];
  logic [31:0] ref_mem [0:15];
  int          cyc = 0;
  bit          checking = 1'b0;

  // Outcome of a request from the rules: fault, extended load value, stored
  // word and how many cycles after the accept edge the response shows up.
  function automatic exp_t predict(input bit w, input logic [1:0] sz, input bit sg,
                                   input logic [31:0] a, input logic [31:0] wd, input int now);
    exp_t        e;
    int          nb;
    int          sh;
    logic [31:0] mask;
    logic [31:0] cur;
    logic [31:0] v;
    e.fault = (a < 32'h7FF0_0000) || (a > 32'h7FFF_FFFF) || (sz == 2'd3) ||
              ((sz == 2'd1) && a[0]) || ((sz == 2'd2) && (a[1:0] != 2'b00));
    e.rdata = 32'h0;
    e.wr    = 1'b0;
    e.waddr = {a[31:2], 2'b00};
    e.wword = 32'h0;
    if (e.fault) begin
      e.due = now;                       // latency 1
      return e;
    end
    nb   = 1 << sz;
    sh   = 8 * int'(a[1:0]);
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
    cur  = (a[31:6] == 26'h1FF_FFFF) ? ref_mem[a[5:2]] : 32'h0;
    if (!w) begin
      v = (cur >> sh) & mask;
      if (sg && v[8 * nb - 1]) v = v | ~mask;
      e.rdata = v;
      e.due   = now + 1;                 // latency 2
    end else begin
      e.wr    = 1'b1;
      e.wword = (cur & ~(mask << sh)) | ((wd & mask) << sh);
      e.due   = (nb == 4) ? now + 1 : now + 2;
    end
    return e;
  endfunction

  // Accept monitor: push a prediction for every handshake the DUT takes
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
    end else begin
      cyc <= cyc + 1;
      if (req_valid && req_ready)
        q.push_back(predict(req_write, req_size, req_sign, req_addr, req_wdata, cyc + 1));
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (!reset && checking) begin
      exp_t f;
      bit   has;
      bit   exp_rv;
      bit   exp_mw;
      has    = (q.size() > 0);
      exp_rv = 1'b0;
      exp_mw = 1'b0;
      if (has) begin
        f      = q[0];
        exp_rv = (f.due == cyc);
        exp_mw = f.wr && (f.due - 1 == cyc);
      end
      chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
      chk("mem_write", 32'(mem_write), 32'(exp_mw));
      chk("req_ready", 32'(req_ready), 32'(!has));
      if (exp_mw) begin
        chk("mem_addr", mem_addr, f.waddr);
        chk("mem_wdata", mem_wdata, f.wword);
      end
      if (exp_rv) begin
        chk("resp_fault", 32'(resp_fault), 32'(f.fault));
        chk("resp_rdata", resp_rdata, f.rdata);
        if (f.wr && (f.waddr[31:6] == 26'h1FF_FFFF)) ref_mem[f.waddr[5:2]] = f.wword;
        void'(q.pop_front());
      end
    end
  end

  // ---------------- directed driver ----------------
  // Issues one request (req_valid stays high afterwards) and checks
  // hand-computed latency, fault and data. Starts and ends on a negedge.
  task automatic do_req(input string name, input bit w, input logic [1:0] sz, input bit sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit exp_f, input logic [31:0] exp_rd, input int exp_lat);
    int k;
    bit got;
    req_write = w;
    req_size  = sz;
    req_sign  = sg;
    req_addr  = a;
    req_wdata = wd;
    req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      chk({name, " accept"}, 32'(req_ready), 32'h1);
      return;
    end
    @(posedge clk);
    got = 1'b0;
    k   = 0;
    while (!got && k < 10) begin
      @(negedge clk);
      k++;
      if (resp_valid) got = 1'b1;
    end
    chk({name, " latency"}, 32'(k), 32'(exp_lat));
    chk({name, " fault"}, 32'(resp_fault), 32'(exp_f));
    chk({name, " rdata"}, resp_rdata, exp_rd);
    $display("txn %-16s w=%0d sz=%0d addr=%h wd=%h -> fault=%0d rdata=%h lat=%0d",
             name, w, sz, a, wd, resp_fault, resp_rdata, k);
  endtask

  int mw0;

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 32'h1);
    chk("rst resp_valid", 32'(resp_valid), 32'h0);
    chk("rst resp_fault", 32'(resp_fault), 32'h0);
    chk("rst resp_rdata", resp_rdata, 32'h0);
    chk("rst mem_write", 32'(mem_write), 32'h0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    #2;
    reset     = 1'b0;
    mem_clear = 1'b0;
    checking  = 1'b1;
    @(negedge clk);

    // Word store / load
    mw0 = mw_count;
    do_req("st_w", 1, 2'd2, 0, 32'h7FFF_FFFC, 32'hDEAD_BEEF, 0, 32'h0, 2);
    chk("st_w pulses", 32'(mw_count - mw0), 32'h1);
    chk("st_w mem", dmem[15], 32'hDEAD_BEEF);
    do_req("ld_w", 0, 2'd2, 0, 32'h7FFF_FFFC, 32'h0, 0, 32'hDEAD_BEEF, 2);

    // Byte store by read-modify-write, then byte loads
    mw0 = mw_count;
    do_req("st_b", 1, 2'd0, 0, 32'h7FFF_FFFD, 32'h0000_005A, 0, 32'h0, 3);
    chk("st_b pulses", 32'(mw_count - mw0), 32'h1);
    chk("st_b mem", dmem[15], 32'hDEAD_5AEF);
    do_req("ld_bs_1", 0, 2'd0, 1, 32'h7FFF_FFFD, 32'h0, 0, 32'h0000_005A, 2);
    do_req("ld_bs_3", 0, 2'd0, 1, 32'h7FFF_FFFF, 32'h0, 0, 32'hFFFF_FFDE, 2);
    do_req("ld_bu_3", 0, 2'd0, 0, 32'h7FFF_FFFF, 32'h0, 0, 32'h0000_00DE, 2);

    // Half store and loads
    do_req("st_h", 1, 2'd1, 0, 32'h7FFF_FFFE, 32'h0000_8001, 0, 32'h0, 3);
    chk("st_h mem", dmem[15], 32'h8001_5AEF);
    do_req("ld_hs", 0, 2'd1, 1, 32'h7FFF_FFFE, 32'h0, 0, 32'hFFFF_8001, 2);
    do_req("ld_hu", 0, 2'd1, 0, 32'h7FFF_FFFE, 32'h0, 0, 32'h0000_8001, 2);

    // Faults: none may touch memory
    mw0 = mw_count;
    do_req("f_w_mis", 0, 2'd2, 0, 32'h7FFF_FFFE, 32'h0, 1, 32'h0, 1);
    do_req("f_h_mis", 0, 2'd1, 1, 32'h7FFF_FFFD, 32'h0, 1, 32'h0, 1);
    do_req("f_range", 0, 2'd0, 0, 32'h7FEF_FFFC, 32'h0, 1, 32'h0, 1);
    do_req("f_rsvd", 0, 2'd3, 0, 32'h7FFF_FFFC, 32'h0, 1, 32'h0, 1);
    do_req("f_st_rng", 1, 2'd2, 0, 32'h7FEF_FFFC, 32'h1234_5678, 1, 32'h0, 1);
    do_req("f_st_rsvd", 1, 2'd3, 0, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 1, 32'h0, 1);
    do_req("f_below", 0, 2'd0, 0, 32'h7FEF_FFFF, 32'h0, 1, 32'h0, 1);
    chk("fault pulses", 32'(mw_count - mw0), 32'h0);
    chk("fault mem", dmem[15], 32'h8001_5AEF);

    // Lowest valid address is in range
    do_req("ld_base", 0, 2'd2, 0, 32'h7FF0_0000, 32'h0, 0, 32'h0, 2);

    // Reset during the READ of a byte store
    mw0       = mw_count;
    req_write = 1'b1;
    req_size  = 2'd0;
    req_sign  = 1'b0;
    req_addr  = 32'h7FFF_FFFC;
    req_wdata = 32'h0000_0011;
    req_valid = 1'b1;
    for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
    @(posedge clk);
    #2;
    reset     = 1'b1;
    req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort mem_write", 32'(mem_write), 32'h0);
      chk("abort resp_valid", 32'(resp_valid), 32'h0);
    end
    #2;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort ready", 32'(req_ready), 32'h1);
    chk("abort pulses", 32'(mw_count - mw0), 32'h0);
    chk("abort mem", dmem[15], 32'h8001_5AEF);
    $display("txn %-16s reset during READ, mem word %h", "abort_st_b", dmem[15]);
    do_req("ld_after", 0, 2'd2, 0, 32'h7FFF_FFFC, 32'h0, 0, 32'h8001_5AEF, 2);

    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("out-of-window writes", 32'(oow_writes), 32'h0);
    chk("model queue drained", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
